// File: rtl/wb_stage_mux.sv
// Writeback stage: selects one of NUM_SRC results, aligns and extends load data,
// and registers the result with rd and write-enable under stall/flush control.
module wb_stage_mux #(
  parameter int XLEN        = 32,
  parameter int NUM_SRC     = 4,
  parameter int SEL_W       = $clog2(NUM_SRC),
  parameter int LOAD_IDX    = 2,
  parameter int DEFAULT_IDX = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [SEL_W-1:0]        wb_sel,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  input  logic [2:0]              load_size,
  input  logic [1:0]              byte_off,
  input  logic [4:0]              rd_in,
  input  logic                    reg_wr_in,
  output logic                    out_valid,
  output logic [XLEN-1:0]         wdata,
  output logic [4:0]              rd_out,
  output logic                    reg_wr_out
);

  localparam logic [2:0] LS_LB  = 3'b000;
  localparam logic [2:0] LS_LH  = 3'b001;
  localparam logic [2:0] LS_LBU = 3'b100;
  localparam logic [2:0] LS_LHU = 3'b101;

  logic [XLEN-1:0] raw;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] sel_data;
  logic            reg_wr;

  assign raw     = src_data[LOAD_IDX*XLEN +: XLEN];
  assign ld_byte = raw[{byte_off, 3'b000} +: 8];
  // Halfword lane ignores byte_off[0]; misaligned halfwords are trapped upstream.
  assign ld_half = raw[{byte_off[1], 4'b0000} +: 16];

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    ld_data = XLEN'($signed(raw[31:0]));
    case (load_size)
      LS_LB:   ld_data = XLEN'($signed(ld_byte));
      LS_LBU:  ld_data = XLEN'(ld_byte);
      LS_LH:   ld_data = XLEN'($signed(ld_half));
      LS_LHU:  ld_data = XLEN'(ld_half);
      default: ld_data = XLEN'($signed(raw[31:0]));
    endcase
  end

  // Out-of-range selects fall back to the default source.
  always_comb begin
    sel_data = src_data[DEFAULT_IDX*XLEN +: XLEN];
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int'(wb_sel) == i) begin
        sel_data = src_data[i*XLEN +: XLEN];
      end
    end
    if (int'(wb_sel) == LOAD_IDX) begin
      sel_data = ld_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      wdata     <= '0;
      rd_out    <= '0;
      reg_wr    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      reg_wr    <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      wdata     <= sel_data;
      rd_out    <= rd_in;
      reg_wr    <= reg_wr_in & in_valid;
    end
  end

  // x0 is hardwired to zero, so it never receives a write strobe.
  assign reg_wr_out = out_valid & reg_wr & (rd_out != 5'd0);

endmodule

// File: tb/tb_wb_stage_mux.sv
// Scoreboarded bench for wb_stage_mux: directed vectors push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_wb_stage_mux;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [1:0]  wb_sel;
  logic [127:0] src4;
  logic [95:0]  src3;
  logic [2:0]  load_size;
  logic [1:0]  byte_off;
  logic [4:0]  rd_in;
  logic        reg_wr_in;

  logic        v4, wr4, v3, wr3;
  logic [31:0] d4, d3;
  logic [4:0]  rd4, rd3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          which;
    logic        v;
    logic [31:0] d;
    logic [4:0]  rd;
    logic        wr;
    string       name;
  } exp_t;

  exp_t sbq[$];

  wb_stage_mux #(.NUM_SRC(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .wb_sel(wb_sel), .src_data(src4), .load_size(load_size), .byte_off(byte_off),
    .rd_in(rd_in), .reg_wr_in(reg_wr_in),
    .out_valid(v4), .wdata(d4), .rd_out(rd4), .reg_wr_out(wr4)
  );

  wb_stage_mux #(.NUM_SRC(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .wb_sel(wb_sel), .src_data(src3), .load_size(load_size), .byte_off(byte_off),
    .rd_in(rd_in), .reg_wr_in(reg_wr_in),
    .out_valid(v3), .wdata(d3), .rd_out(rd3), .reg_wr_out(wr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input int which, input logic v, input logic [31:0] d,
                            input logic [4:0] rd, input logic wr, input string name);
    exp_t e;
    e.which = which; e.v = v; e.d = d; e.rd = rd; e.wr = wr; e.name = name;
    sbq.push_back(e);
  endtask

  // Inputs change just after the negedge so the monitor sees the previous capture first.
  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(input logic iv, input logic [1:0] sel, input logic [2:0] lsz,
                     input logic [1:0] off, input logic [4:0] rd, input logic rw);
    in_valid = iv; wb_sel = sel; load_size = lsz; byte_off = off; rd_in = rd; reg_wr_in = rw;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.which == 3) begin
          check({e.name, ".valid"}, {31'b0, v3},  {31'b0, e.v});
          check({e.name, ".wdata"}, d3,           e.d);
          check({e.name, ".rd"},    {27'b0, rd3}, {27'b0, e.rd});
          check({e.name, ".wr"},    {31'b0, wr3}, {31'b0, e.wr});
        end else begin
          check({e.name, ".valid"}, {31'b0, v4},  {31'b0, e.v});
          check({e.name, ".wdata"}, d4,           e.d);
          check({e.name, ".rd"},    {27'b0, rd4}, {27'b0, e.rd});
          check({e.name, ".wr"},    {31'b0, wr4}, {31'b0, e.wr});
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic drain(input string name);
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected entries left, required 0", name, sbq.size());
    end
  endtask

  initial begin : stimulus
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drv(1'b0, 2'd0, 3'b010, 2'd0, 5'd0, 1'b0);
    src4 = {32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF, 32'h00000104};
    src3 = {32'h55AA55AA, 32'hDEADBEEF, 32'h00000104};

    #2;
    check("reset.valid", {31'b0, v4},  32'd0);
    check("reset.wdata", d4,           32'd0);
    check("reset.rd",    {27'b0, rd4}, 32'd0);
    check("reset.wr",    {31'b0, wr4}, 32'd0);

    @(negedge clk); #1;
    rst = 1'b1;

    // Plain source select, one result per cycle.
    next(); drv(1'b1, 2'd0, 3'b010, 2'd0, 5'd5, 1'b1); expect_out(4, 1, 32'h00000104, 5, 1, "sel0");
    next(); drv(1'b1, 2'd1, 3'b010, 2'd0, 5'd5, 1'b1); expect_out(4, 1, 32'hDEADBEEF, 5, 1, "sel1");
    next(); drv(1'b1, 2'd3, 3'b010, 2'd0, 5'd5, 1'b1); expect_out(4, 1, 32'hCAFEF00D, 5, 1, "sel3");

    // Load alignment on raw = 0x80FF7F01.
    next(); src4[64 +: 32] = 32'h80FF7F01;
    drv(1'b1, 2'd2, 3'b000, 2'd3, 5'd7, 1'b1); expect_out(4, 1, 32'hFFFFFF80, 7, 1, "lb_off3");
    next(); drv(1'b1, 2'd2, 3'b100, 2'd1, 5'd7, 1'b1); expect_out(4, 1, 32'h0000007F, 7, 1, "lbu_off1");
    next(); drv(1'b1, 2'd2, 3'b001, 2'd2, 5'd7, 1'b1); expect_out(4, 1, 32'hFFFF80FF, 7, 1, "lh_off2");
    next(); drv(1'b1, 2'd2, 3'b101, 2'd0, 5'd7, 1'b1); expect_out(4, 1, 32'h00007F01, 7, 1, "lhu_off0");
    next(); drv(1'b1, 2'd2, 3'b010, 2'd0, 5'd7, 1'b1); expect_out(4, 1, 32'h80FF7F01, 7, 1, "lw");
    next(); drv(1'b1, 2'd2, 3'b011, 2'd1, 5'd7, 1'b1); expect_out(4, 1, 32'h80FF7F01, 7, 1, "code011_as_lw");
    next(); drv(1'b1, 2'd2, 3'b101, 2'd3, 5'd7, 1'b1); expect_out(4, 1, 32'h000080FF, 7, 1, "lhu_off3");

    // Stall for three cycles with changing inputs: outputs frozen.
    next(); stall = 1'b1; drv(1'b0, 2'd0, 3'b010, 2'd0, 5'd9, 1'b0); expect_out(4, 1, 32'h000080FF, 7, 1, "stall1");
    next(); drv(1'b1, 2'd1, 3'b000, 2'd2, 5'd10, 1'b1); expect_out(4, 1, 32'h000080FF, 7, 1, "stall2");
    next(); drv(1'b1, 2'd3, 3'b001, 2'd1, 5'd11, 1'b0); expect_out(4, 1, 32'h000080FF, 7, 1, "stall3");

    // Flush wins over stall; data and rd hold.
    next(); flush = 1'b1; drv(1'b1, 2'd0, 3'b010, 2'd0, 5'd12, 1'b1); expect_out(4, 0, 32'h000080FF, 7, 0, "flush_stall");

    // x0 destination: data updates, no strobe.
    next(); stall = 1'b0; flush = 1'b0;
    drv(1'b1, 2'd1, 3'b010, 2'd0, 5'd0, 1'b1); expect_out(4, 1, 32'hDEADBEEF, 0, 0, "rd_x0");
    // Bubble: data updates, no strobe.
    next(); drv(1'b0, 2'd0, 3'b010, 2'd0, 5'd3, 1'b1); expect_out(4, 0, 32'h00000104, 3, 0, "bubble");
    // Flush alone kills the capture.
    next(); flush = 1'b1; drv(1'b1, 2'd3, 3'b010, 2'd0, 5'd4, 1'b1); expect_out(4, 0, 32'h00000104, 3, 0, "flush_only");

    // Out-of-range select on the 3-source instance falls back to source 1.
    next(); flush = 1'b0; drv(1'b1, 2'd3, 3'b010, 2'd0, 5'd6, 1'b1); expect_out(3, 1, 32'hDEADBEEF, 6, 1, "n3_sel3");
    next(); drv(1'b1, 2'd1, 3'b010, 2'd0, 5'd5, 1'b1); expect_out(4, 1, 32'hDEADBEEF, 5, 1, "pre_reset");

    // Asynchronous reset in the middle of a stall.
    next(); stall = 1'b1;
    drain("drain_pre_reset");
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("async_reset.valid", {31'b0, v4},  32'd0);
    check("async_reset.wdata", d4,           32'd0);
    check("async_reset.rd",    {27'b0, rd4}, 32'd0);
    check("async_reset.wr",    {31'b0, wr4}, 32'd0);

    // First capture after release.
    @(negedge clk); #1;
    rst = 1'b1; stall = 1'b0;
    drv(1'b1, 2'd0, 3'b010, 2'd0, 5'd2, 1'b1); expect_out(4, 1, 32'h00000104, 2, 1, "post_reset");
    next(); drv(1'b0, 2'd0, 3'b010, 2'd0, 5'd0, 1'b0);
    drain("drain_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
